picorv_pcpi_muldiv: RTL and testbench

- Unified iterative RV32M/RV64M multiply/divide coprocessor on the PCPI bus.
- Replaces the separate mul and div units beside picorv_core in picorv_ez.
- Generalised over XLEN. Radix (bits per cycle) is configurable separately for multiply and divide.
- Adds defined div-by-zero and overflow results, a single shared datapath and FSM, and optional RV64 word ops.

---
 rtl/picorv_pcpi_muldiv_if.sv | 23 ++
 rtl/picorv_pcpi_muldiv.sv | 174 +++++++++++++++++
 tb/tb_picorv_pcpi_muldiv.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/picorv_pcpi_muldiv_if.sv
// PCPI handshake between the core (master) and a coprocessor (slave).
interface picorv_pcpi_muldiv_if #(
    parameter int XLEN = 64
);
    logic            pcpi_valid;
    logic [31:0]     pcpi_insn;
    logic [XLEN-1:0] pcpi_rs1;
    logic [XLEN-1:0] pcpi_rs2;
    logic            pcpi_wr;
    logic [XLEN-1:0] pcpi_rd;
    logic            pcpi_wait;
    logic            pcpi_ready;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );
endinterface

// File: rtl/picorv_pcpi_muldiv.sv
// Iterative RV32M/RV64M multiply/divide PCPI coprocessor with one shared shift datapath.
// Define PICORV_PCPI_MULDIV_WOPS_EN (XLEN=64 only) to also claim the RV64 *W word ops.
module picorv_pcpi_muldiv #(
    parameter int XLEN      = 64,
    parameter int MUL_STEPS = 2,
    parameter int DIV_STEPS = 1
) (
    input  logic                clock,
    input  logic                reset,
    picorv_pcpi_muldiv_if.slave pcpi
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] MUL_CYCLES = CNT_W'(XLEN / MUL_STEPS);
    localparam logic [CNT_W-1:0] DIV_CYCLES = CNT_W'(XLEN / DIV_STEPS);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_next;
    logic              cooldown;
    logic [CNT_W-1:0]  cnt, cnt_init;
    logic [2*XLEN-1:0] acc, acc_init, mul_next, div_next, prod;
    logic [XLEN-1:0]   opb, div_val, result;
    logic [XLEN:0]     mul_sum, div_trial;
    logic              is_div, neg_res, sel_alt;

    logic [2:0]        funct3;
    logic              base_op, word_op, claim;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag;
    logic              ready_o, wait_o;
    logic              unused_insn_bits;

    assign funct3  = pcpi.pcpi_insn[14:12];
    assign base_op = (pcpi.pcpi_insn[6:0] == 7'b0110011) && (pcpi.pcpi_insn[31:25] == 7'b0000001);
    assign unused_insn_bits = ^{pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7]};

`ifdef PICORV_PCPI_MULDIV_WOPS_EN
    localparam logic [CNT_W-1:0] MULW_CYCLES = CNT_W'(32 / MUL_STEPS);
    localparam logic [CNT_W-1:0] DIVW_CYCLES = CNT_W'(32 / DIV_STEPS);
    logic is_word;

    assign word_op = (XLEN == 64) && (pcpi.pcpi_insn[6:0] == 7'b0111011) &&
                     (pcpi.pcpi_insn[31:25] == 7'b0000001) && (funct3 == 3'b000 || funct3[2]);
`else
    assign word_op = 1'b0;
`endif

    assign claim = pcpi.pcpi_valid && (state == IDLE) && !cooldown && (base_op || word_op);

    // Operand conditioning: extension for word ops, then sign-magnitude split.
    always_comb begin
        a_ext    = pcpi.pcpi_rs1;
        b_ext    = pcpi.pcpi_rs2;
        a_signed = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
        b_signed = funct3 inside {3'b001, 3'b100, 3'b110};
`ifdef PICORV_PCPI_MULDIV_WOPS_EN
        if (word_op) begin
            // MULW keeps only the low 32 product bits, so it runs unsigned.
            a_signed = funct3 inside {3'b100, 3'b110};
            b_signed = a_signed;
            a_ext    = a_signed ? XLEN'($signed(pcpi.pcpi_rs1[31:0])) : XLEN'(pcpi.pcpi_rs1[31:0]);
            b_ext    = b_signed ? XLEN'($signed(pcpi.pcpi_rs2[31:0])) : XLEN'(pcpi.pcpi_rs2[31:0]);
        end
`endif
        a_neg = a_signed & a_ext[XLEN-1];
        b_neg = b_signed & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
    end

    always_comb begin
        if (funct3[2]) begin
            acc_init = {{XLEN{1'b0}}, a_mag};
            cnt_init = DIV_CYCLES;
        end else begin
            acc_init = {{XLEN{1'b0}}, b_mag};
            cnt_init = MUL_CYCLES;
        end
`ifdef PICORV_PCPI_MULDIV_WOPS_EN
        if (word_op) begin
            // Word dividend sits in the top half of the quotient field so 32 shifts finish it.
            acc_init = funct3[2] ? acc_init << 32 : acc_init;
            cnt_init = funct3[2] ? DIVW_CYCLES : MULW_CYCLES;
        end
`endif
    end

    // NOTE: combinational loops use blocking '=' so each unrolled stage sees the previous one.
    always_comb begin
        mul_sum   = '0;
        div_trial = '0;
        mul_next  = acc;
        for (int i = 0; i < MUL_STEPS; i++) begin
            mul_sum  = {1'b0, mul_next[2*XLEN-1:XLEN]} + (mul_next[0] ? {1'b0, opb} : '0);
            mul_next = {mul_sum, mul_next[XLEN-1:1]};
        end
        div_next = acc;
        for (int i = 0; i < DIV_STEPS; i++) begin
            div_trial = {div_next[2*XLEN-1:XLEN], div_next[XLEN-1]} - {1'b0, opb};
            if (div_trial[XLEN])
                div_next = {div_next[2*XLEN-2:0], 1'b0};
            else
                div_next = {div_trial[XLEN-1:0], div_next[XLEN-2:0], 1'b1};
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on claim before being read.
    always_ff @(posedge clock) begin
        if (claim) begin
            is_div  <= funct3[2];
            sel_alt <= funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
            neg_res <= funct3[2] ? (funct3[1] ? a_neg : ((a_neg ^ b_neg) && (b_ext != '0)))
                                 : (a_neg ^ b_neg);
            acc     <= acc_init;
            opb     <= funct3[2] ? b_mag : a_mag;
            cnt     <= cnt_init;
`ifdef PICORV_PCPI_MULDIV_WOPS_EN
            is_word <= word_op;
`endif
        end else if (state == CALC && cnt != '0) begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_comb begin
        prod    = neg_res ? -acc : acc;
        div_val = sel_alt ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (neg_res)
            div_val = -div_val;
        if (is_div)
            result = div_val;
        else
            result = sel_alt ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
`ifdef PICORV_PCPI_MULDIV_WOPS_EN
        if (is_word)
            result = is_div ? XLEN'($signed(div_val[31:0])) : XLEN'($signed(acc[XLEN-32 +: 32]));
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cooldown <= 1'b0;
        end else begin
            state    <= state_next;
            cooldown <= (state == DONE);
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_next = state;
        wait_o     = 1'b0;
        ready_o    = 1'b0;
        unique case (state)
            IDLE: if (claim) state_next = CALC;
            CALC: begin
                wait_o = 1'b1;
                if (cnt == '0) state_next = DONE;
            end
            DONE: begin
                ready_o    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign pcpi.pcpi_wait  = wait_o;
    assign pcpi.pcpi_ready = ready_o;
    assign pcpi.pcpi_wr    = ready_o;
    assign pcpi.pcpi_rd    = ready_o ? result : '0;
endmodule

// File: tb/tb_picorv_pcpi_muldiv.sv
// Randomised and directed checks of picorv_pcpi_muldiv against an arithmetic reference model.
`timescale 1ns/1ps
module tb_picorv_pcpi_muldiv;
    localparam int XLEN      = 64;
    localparam int MUL_STEPS = 2;
    localparam int DIV_STEPS = 1;
    localparam int LIMIT     = 300;
    localparam logic [6:0] OP_BASE = 7'b0110011;
    localparam logic [6:0] OP_WORD = 7'b0111011;
    localparam logic [XLEN-1:0] ONES = '1;
    localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    picorv_pcpi_muldiv_if #(.XLEN(XLEN)) bus ();

    picorv_pcpi_muldiv #(.XLEN(XLEN), .MUL_STEPS(MUL_STEPS), .DIV_STEPS(DIV_STEPS)) dut (
        .clock (clock),
        .reset (reset),
        .pcpi  (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk_insn(input logic [6:0] opcode, input logic [2:0] f3, input logic [6:0] f7);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opcode};
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input bit word);
        int width;
        width = word ? 32 : XLEN;
        return (f3[2] ? width / DIV_STEPS : width / MUL_STEPS) + 2;
    endfunction

    // Full-precision arithmetic reference for the base ops.
    function automatic logic [XLEN-1:0] ref_base(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic signed [2*XLEN-1:0] sa, sb, ua, ub, p;
        logic signed [XLEN-1:0]   sr;
        sa = $signed(a);
        sb = $signed(b);
        ua = {{XLEN{1'b0}}, a};
        ub = {{XLEN{1'b0}}, b};
        case (f3)
            3'd0: begin p = ua * ub; return p[XLEN-1:0]; end
            3'd1: begin p = sa * sb; return p[2*XLEN-1:XLEN]; end
            3'd2: begin p = sa * ub; return p[2*XLEN-1:XLEN]; end
            3'd3: begin p = ua * ub; return p[2*XLEN-1:XLEN]; end
            3'd4: begin
                if (b == 0) return ONES;
                if (a == MIN && b == ONES) return a;
                sr = $signed(a) / $signed(b);
                return sr;
            end
            3'd5: return (b == 0) ? ONES : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == ONES) return '0;
                sr = $signed(a) % $signed(b);
                return sr;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] ref_word(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [31:0]        a32, b32, r32;
        logic signed [31:0] s32;
        logic signed [XLEN-1:0] wide;
        a32 = a[31:0];
        b32 = b[31:0];
        case (f3)
            3'd0: r32 = a32 * b32;
            3'd4: begin
                if (b32 == 0) r32 = '1;
                else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
                else begin s32 = $signed(a32) / $signed(b32); r32 = s32; end
            end
            3'd5: r32 = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
            3'd6: begin
                if (b32 == 0) r32 = a32;
                else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = '0;
                else begin s32 = $signed(a32) % $signed(b32); r32 = s32; end
            end
            default: r32 = (b32 == 0) ? a32 : a32 % b32;
        endcase
        s32  = $signed(r32);
        wide = s32;
        return wide;
    endfunction

    function automatic logic [XLEN-1:0] pick();
        logic [XLEN-1:0] v;
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = ONES;
            2: v = MIN;
            3: begin
                v = XLEN'($urandom_range(0, 20));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Issues one instruction, holds valid until ready, checks latency, result and idle outputs.
    task automatic run_op(input string name, input logic [31:0] insn, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] expv, input int lat);
        int cyc;
        int leaks;
        bit seen;
        logic [XLEN-1:0] got_rd;
        logic got_wr;
        @(negedge clock);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = insn;
        bus.pcpi_rs1   = a;
        bus.pcpi_rs2   = b;
        @(posedge clock);
        cyc = 0; leaks = 0; seen = 1'b0; got_rd = '0; got_wr = 1'b0;
        while (!seen && cyc < LIMIT) begin
            @(negedge clock);
            cyc++;
            if (bus.pcpi_ready === 1'b1) begin
                seen   = 1'b1;
                got_rd = bus.pcpi_rd;
                got_wr = bus.pcpi_wr;
                bus.pcpi_valid = 1'b0;
            end else if (bus.pcpi_rd !== '0 || bus.pcpi_wr !== 1'b0 || bus.pcpi_wait !== 1'b1) begin
                leaks++;
            end
        end
        bus.pcpi_valid = 1'b0;
        vectors++;
        if (!seen || cyc != lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d (ready seen %0d) want %0d", name, cyc, seen, lat);
        end
        vectors++;
        if (got_rd !== expv) begin
            miscompares++;
            $display("FAIL %s rd: got %h want %h (rs1=%h rs2=%h)", name, got_rd, expv, a, b);
        end
        vectors++;
        if (got_wr !== 1'b1) begin
            miscompares++;
            $display("FAIL %s wr: got %b want 1", name, got_wr);
        end
        vectors++;
        if (leaks != 0) begin
            miscompares++;
            $display("FAIL %s busy outputs: got %0d bad cycles want 0", name, leaks);
        end
        @(negedge clock);
        vectors++;
        if (bus.pcpi_ready !== 1'b0 || bus.pcpi_rd !== '0 || bus.pcpi_wait !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after-done: got ready=%b wait=%b rd=%h want 0/0/0",
                     name, bus.pcpi_ready, bus.pcpi_wait, bus.pcpi_rd);
        end
        @(negedge clock);
    endtask

    // Holds an instruction valid and expects the unit to ignore it entirely.
    task automatic hold_unclaimed(input string name, input logic [31:0] insn, input int cycles);
        int busy;
        busy = 0;
        @(negedge clock);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = insn;
        bus.pcpi_rs1   = 64'h0000_0001_0000_0010;
        bus.pcpi_rs2   = 64'h8;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (bus.pcpi_wait !== 1'b0 || bus.pcpi_ready !== 1'b0 || bus.pcpi_wr !== 1'b0 || bus.pcpi_rd !== '0)
                busy++;
        end
        bus.pcpi_valid = 1'b0;
        vectors++;
        if (busy != 0) begin
            miscompares++;
            $display("FAIL %s unclaimed: got %0d active cycles want 0", name, busy);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = mk_insn(OP_BASE, 3'd0, 7'b0000001);
        bus.pcpi_rs1   = 64'd3;
        bus.pcpi_rs2   = 64'd5;
        reset = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        vectors++;
        if ({bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_wr} !== 3'b000 || bus.pcpi_rd !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: got wait=%b ready=%b wr=%b rd=%h want 0", bus.pcpi_wait,
                     bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_rd);
        end
        bus.pcpi_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if ({bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_wr} !== 3'b000 || bus.pcpi_rd !== '0) begin
            miscompares++;
            $display("FAIL post-reset idle: got wait=%b ready=%b rd=%h want 0", bus.pcpi_wait,
                     bus.pcpi_ready, bus.pcpi_rd);
        end
    endtask

    task automatic test_directed();
        run_op("mul_7_m3", mk_insn(OP_BASE, 3'd0, 7'b0000001), 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
               64'hFFFF_FFFF_FFFF_FFEB, 34);
        run_op("mulh_min", mk_insn(OP_BASE, 3'd1, 7'b0000001), MIN, MIN, 64'h4000_0000_0000_0000, 34);
        run_op("mulhu_ones", mk_insn(OP_BASE, 3'd3, 7'b0000001), ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        run_op("mulhsu_m1_2", mk_insn(OP_BASE, 3'd2, 7'b0000001), ONES, 64'd2, ONES, 34);
        run_op("div_m7_2", mk_insn(OP_BASE, 3'd4, 7'b0000001), -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("rem_m7_2", mk_insn(OP_BASE, 3'd6, 7'b0000001), -64'd7, 64'd2, ONES, 66);
        run_op("divu_by0", mk_insn(OP_BASE, 3'd5, 7'b0000001), 64'd5, 64'd0, ONES, 66);
        run_op("remu_by0", mk_insn(OP_BASE, 3'd7, 7'b0000001), 64'd5, 64'd0, 64'd5, 66);
        run_op("div_by0_neg", mk_insn(OP_BASE, 3'd4, 7'b0000001), -64'd9, 64'd0, ONES, 66);
        run_op("rem_by0_neg", mk_insn(OP_BASE, 3'd6, 7'b0000001), -64'd9, 64'd0, -64'd9, 66);
        run_op("div_ovf", mk_insn(OP_BASE, 3'd4, 7'b0000001), MIN, ONES, MIN, 66);
        run_op("rem_ovf", mk_insn(OP_BASE, 3'd6, 7'b0000001), MIN, ONES, 64'd0, 66);
    endtask

    task automatic test_random();
        logic [2:0] f3;
        logic [XLEN-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op($sformatf("rand%0d_f%0d", i, f3), mk_insn(OP_BASE, f3, 7'b0000001), a, b,
                   ref_base(f3, a, b), exp_lat(f3, 1'b0));
        end
    endtask

    task automatic test_reset_mid();
        int readies;
        @(negedge clock);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = mk_insn(OP_BASE, 3'd4, 7'b0000001);
        bus.pcpi_rs1   = -64'd100;
        bus.pcpi_rs2   = 64'd3;
        @(posedge clock);
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        bus.pcpi_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        vectors++;
        if (bus.pcpi_wait !== 1'b0 || bus.pcpi_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid state: got wait=%b ready=%b want 0/0", bus.pcpi_wait, bus.pcpi_ready);
        end
        readies = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.pcpi_ready !== 1'b0 || bus.pcpi_wait !== 1'b0) readies++;
        end
        vectors++;
        if (readies != 0) begin
            miscompares++;
            $display("FAIL reset_mid discard: got %0d active cycles want 0", readies);
        end
        run_op("mul_3_4", mk_insn(OP_BASE, 3'd0, 7'b0000001), 64'd3, 64'd4, 64'd12, 34);
    endtask

    task automatic test_unclaimed();
        hold_unclaimed("add", mk_insn(OP_BASE, 3'd0, 7'b0000000), 200);
        hold_unclaimed("wrong_opcode", mk_insn(7'b0010011, 3'd0, 7'b0000001), 50);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int nready;
        int first_at, second_at;
        logic [XLEN-1:0] rd1, rd2;
        @(negedge clock);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = mk_insn(OP_BASE, 3'd0, 7'b0000001);
        bus.pcpi_rs1   = 64'd11;
        bus.pcpi_rs2   = 64'd13;
        @(posedge clock);
        cyc = 0; nready = 0; first_at = -1; second_at = -1; rd1 = '0; rd2 = '0;
        while (nready < 2 && cyc < LIMIT) begin
            @(negedge clock);
            cyc++;
            if (bus.pcpi_ready === 1'b1) begin
                nready++;
                if (nready == 1) begin
                    first_at = cyc;
                    rd1 = bus.pcpi_rd;
                    bus.pcpi_insn = mk_insn(OP_BASE, 3'd5, 7'b0000001);
                    bus.pcpi_rs1  = 64'd100;
                    bus.pcpi_rs2  = 64'd7;
                end else begin
                    second_at = cyc;
                    rd2 = bus.pcpi_rd;
                end
            end
        end
        bus.pcpi_valid = 1'b0;
        vectors++;
        if (first_at != 34 || rd1 !== 64'd143) begin
            miscompares++;
            $display("FAIL b2b first: got cycle %0d rd %h want 34 / %h", first_at, rd1, 64'd143);
        end
        vectors++;
        if (second_at != 34 + 2 + 66 || rd2 !== 64'd14) begin
            miscompares++;
            $display("FAIL b2b second: got cycle %0d rd %h want %0d / %h", second_at, rd2, 34 + 2 + 66, 64'd14);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_word_ops();
`ifdef PICORV_PCPI_MULDIV_WOPS_EN
        logic [2:0] f3;
        logic [XLEN-1:0] a, b;
        run_op("mulw", mk_insn(OP_WORD, 3'd0, 7'b0000001), 64'hDEAD_BEEF_7FFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFE, exp_lat(3'd0, 1'b1));
        run_op("divuw", mk_insn(OP_WORD, 3'd5, 7'b0000001), 64'h0000_0001_0000_0010, 64'h8,
               64'd2, exp_lat(3'd5, 1'b1));
        for (int i = 0; i < 15; i++) begin
            case ($urandom_range(0, 4))
                0: f3 = 3'd0;
                1: f3 = 3'd4;
                2: f3 = 3'd5;
                3: f3 = 3'd6;
                default: f3 = 3'd7;
            endcase
            a = pick();
            b = pick();
            run_op($sformatf("wrand%0d_f%0d", i, f3), mk_insn(OP_WORD, f3, 7'b0000001), a, b,
                   ref_word(f3, a, b), exp_lat(f3, 1'b1));
        end
        hold_unclaimed("word_f3_1", mk_insn(OP_WORD, 3'd1, 7'b0000001), 40);
`else
        hold_unclaimed("mulw_off", mk_insn(OP_WORD, 3'd0, 7'b0000001), 100);
        hold_unclaimed("divuw_off", mk_insn(OP_WORD, 3'd5, 7'b0000001), 100);
`endif
    endtask

    initial begin
        bus.pcpi_valid = 1'b0;
        bus.pcpi_insn  = '0;
        bus.pcpi_rs1   = '0;
        bus.pcpi_rs2   = '0;
        test_reset();
        test_directed();
        test_reset_mid();
        test_unclaimed();
        test_back_to_back();
        test_random();
        test_word_ops();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
